// File: rtl/mult_store.sv
// ---------------------------------------------------------------------------
// mult_store
//   Layer-2 (softmax-input) multiply-accumulate bank. One unsigned input value
//   is broadcast each cycle to SOFTMAX_NODES independent lanes. Each lane
//   multiplies it by its own two's-complement weight and adds the product into
//   an accumulator that starts from a per-lane bias value.
//
// Ports
//   clk             in   1                    rising-edge clock
//   clr             in   1                    synchronous active-high reset:
//                                             acc <= bias (or the bias bus
//                                             value when biasWriteEnable=1)
//   layer2In        in   IN_W                 unsigned input, shared by lanes
//   weightsIn       in   SOFTMAX_NODES*WGT_W  lane i weight at [i*WGT_W +: WGT_W]
//   biasWriteEnable in   1                    load biasesIn into bias registers
//   biasesIn        in   SOFTMAX_NODES*OUT_W  lane i bias at [i*OUT_W +: OUT_W]
//   sumOut          out  SOFTMAX_NODES*OUT_W  lane i accumulator, registered
// ---------------------------------------------------------------------------
module mult_store #(
    parameter int SOFTMAX_NODES = 2,
    parameter int IN_W          = 3,
    parameter int WGT_W         = 3,
    parameter int OUT_W         = 6
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic [IN_W-1:0]                layer2In,
    input  logic [SOFTMAX_NODES*WGT_W-1:0] weightsIn,
    input  logic                           biasWriteEnable,
    input  logic [SOFTMAX_NODES*OUT_W-1:0] biasesIn,
    output logic [SOFTMAX_NODES*OUT_W-1:0] sumOut
);

    // The exact signed product of a zero-extended IN_W value and a WGT_W
    // weight fits in IN_W+WGT_W+1 bits. Sign-extending or truncating that
    // product to OUT_W bits gives the same bits as forming the product
    // directly modulo 2^OUT_W from operands extended to OUT_W bits, which is
    // what each lane does below. This needs OUT_W > IN_W and OUT_W >= WGT_W.

    genvar gi;
    generate
        for (gi = 0; gi < SOFTMAX_NODES; gi++) begin : g_lane
            logic [WGT_W-1:0] weight;
            logic [OUT_W-1:0] bias_in;
            logic [OUT_W-1:0] in_ext;
            logic [OUT_W-1:0] wgt_ext;
            logic [OUT_W-1:0] prod;
            logic [OUT_W-1:0] bias_q;
            logic [OUT_W-1:0] bias_d;
            logic [OUT_W-1:0] acc_q;
            logic [OUT_W-1:0] acc_d;

            assign weight  = weightsIn[gi*WGT_W +: WGT_W];
            assign bias_in = biasesIn[gi*OUT_W +: OUT_W];

            // Input is unsigned (zero-extend), weight is signed (sign-extend).
            assign in_ext  = {{(OUT_W-IN_W){1'b0}}, layer2In};
            assign wgt_ext = {{(OUT_W-WGT_W){weight[WGT_W-1]}}, weight};
            assign prod    = in_ext * wgt_ext;

            always_comb begin
                bias_d = bias_q;
                acc_d  = acc_q + prod;   // wraps modulo 2^OUT_W
                if (biasWriteEnable) begin
                    bias_d = bias_in;
                end
                if (clr) begin
                    // A bias written in the same clr cycle bypasses straight
                    // into the accumulator rather than the stale register.
                    acc_d = biasWriteEnable ? bias_in : bias_q;
                end
            end

            // Bias registers deliberately keep their value through clr.
            always_ff @(posedge clk) begin
                bias_q <= bias_d;
                acc_q  <= acc_d;
            end

            assign sumOut[gi*OUT_W +: OUT_W] = acc_q;
        end
    endgenerate

endmodule

// File: tb/tb_mult_store.sv
module tb_mult_store;

    localparam int N     = 2;
    localparam int IN_W  = 3;
    localparam int WGT_W = 3;
    localparam int OUT_W = 6;

    logic                   clk;
    logic                   clr;
    logic [IN_W-1:0]        layer2In;
    logic [N*WGT_W-1:0]     weightsIn;
    logic                   biasWriteEnable;
    logic [N*OUT_W-1:0]     biasesIn;
    logic [N*OUT_W-1:0]     sumOut;

    int n_cmp;
    int n_err;

    mult_store #(
        .SOFTMAX_NODES(N),
        .IN_W(IN_W),
        .WGT_W(WGT_W),
        .OUT_W(OUT_W)
    ) dut (
        .clk(clk),
        .clr(clr),
        .layer2In(layer2In),
        .weightsIn(weightsIn),
        .biasWriteEnable(biasWriteEnable),
        .biasesIn(biasesIn),
        .sumOut(sumOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic bwe, input logic [IN_W-1:0] x,
                         input logic [N*WGT_W-1:0] w, input logic [N*OUT_W-1:0] b);
        clr             = c;
        biasWriteEnable = bwe;
        layer2In        = x;
        weightsIn       = w;
        biasesIn        = b;
    endtask

    task automatic test_reset();
        logic [N*OUT_W-1:0] exp;
        drive(1'b1, 1'b1, 3'd0, 6'd0, {6'd3, 6'b111111});
        step();
        exp = {6'd3, 6'b111111};
        n_cmp++;
        if (sumOut !== exp) begin
            n_err++;
            $display("FAIL reset_bias_load: sumOut=%b expected %b", sumOut, exp);
        end
        $display("reset_bias_load: sumOut=%b", sumOut);
    endtask

    task automatic test_accumulate();
        logic [N*OUT_W-1:0] exp;
        drive(1'b0, 1'b0, 3'd1, 6'b011_111, {6'd3, 6'b111111});
        step();
        exp = {6'd6, 6'b111110};
        n_cmp++;
        if (sumOut !== exp) begin
            n_err++;
            $display("FAIL accumulate_1: sumOut=%b expected %b", sumOut, exp);
        end
        $display("accumulate_1: sumOut=%b", sumOut);
        step();
        exp = {6'd9, 6'b111101};
        n_cmp++;
        if (sumOut !== exp) begin
            n_err++;
            $display("FAIL accumulate_2: sumOut=%b expected %b", sumOut, exp);
        end
        $display("accumulate_2: sumOut=%b", sumOut);
    endtask

    task automatic test_scaling();
        logic [N*OUT_W-1:0] exp;
        drive(1'b0, 1'b0, 3'd2, 6'b011_111, {6'd3, 6'b111111});
        step();
        exp = {6'd15, 6'b111011};
        n_cmp++;
        if (sumOut !== exp) begin
            n_err++;
            $display("FAIL input_scaling: sumOut=%b expected %b", sumOut, exp);
        end
        $display("input_scaling: sumOut=%b", sumOut);
    endtask

    task automatic test_idle();
        logic [N*OUT_W-1:0] exp;
        // Zero weights with a nonzero input must hold the accumulators.
        drive(1'b0, 1'b0, 3'd7, 6'd0, 12'd0);
        step();
        step();
        exp = {6'd15, 6'b111011};
        n_cmp++;
        if (sumOut !== exp) begin
            n_err++;
            $display("FAIL idle_hold: sumOut=%b expected %b", sumOut, exp);
        end
        $display("idle_hold: sumOut=%b", sumOut);
    endtask

    task automatic test_clear_stored();
        logic [N*OUT_W-1:0] exp;
        drive(1'b1, 1'b0, 3'd5, 6'b011_011, 12'd0);
        step();
        exp = {6'd3, 6'b111111};
        n_cmp++;
        if (sumOut !== exp) begin
            n_err++;
            $display("FAIL clear_stored_bias: sumOut=%b expected %b", sumOut, exp);
        end
        $display("clear_stored_bias: sumOut=%b", sumOut);
        // clr held a second cycle: still the stored bias, no accumulation.
        step();
        n_cmp++;
        if (sumOut !== exp) begin
            n_err++;
            $display("FAIL clear_held: sumOut=%b expected %b", sumOut, exp);
        end
        $display("clear_held: sumOut=%b", sumOut);
    endtask

    task automatic test_wrap();
        logic [N*OUT_W-1:0] exp;
        drive(1'b1, 1'b1, 3'd0, 6'd0, {6'd31, 6'd0});
        step();
        exp = {6'd31, 6'd0};
        n_cmp++;
        if (sumOut !== exp) begin
            n_err++;
            $display("FAIL wrap_bias_load: sumOut=%b expected %b", sumOut, exp);
        end
        $display("wrap_bias_load: sumOut=%b", sumOut);
        drive(1'b0, 1'b0, 3'd7, {3'd3, 3'd0}, 12'd0);
        step();
        exp = {6'b110100, 6'd0};
        n_cmp++;
        if (sumOut !== exp) begin
            n_err++;
            $display("FAIL wrap_around: sumOut=%b expected %b", sumOut, exp);
        end
        $display("wrap_around: sumOut=%b", sumOut);
    endtask

    task automatic test_bias_write_no_clr();
        logic [N*OUT_W-1:0] exp;
        // From {-12, 0}: lane1 += 1*1, lane0 += 1*2 while new biases {5,-4} load.
        drive(1'b0, 1'b1, 3'd1, {3'd1, 3'd2}, {6'd5, 6'b111100});
        step();
        exp = {6'b110101, 6'd2};
        n_cmp++;
        if (sumOut !== exp) begin
            n_err++;
            $display("FAIL bias_write_accumulates: sumOut=%b expected %b", sumOut, exp);
        end
        $display("bias_write_accumulates: sumOut=%b", sumOut);
        drive(1'b1, 1'b0, 3'd1, {3'd1, 3'd2}, 12'd0);
        step();
        exp = {6'd5, 6'b111100};
        n_cmp++;
        if (sumOut !== exp) begin
            n_err++;
            $display("FAIL bias_write_then_clr: sumOut=%b expected %b", sumOut, exp);
        end
        $display("bias_write_then_clr: sumOut=%b", sumOut);
    endtask

    task automatic test_extremes();
        logic [N*OUT_W-1:0] exp;
        drive(1'b1, 1'b1, 3'd0, 6'd0, 12'd0);
        step();
        exp = 12'd0;
        n_cmp++;
        if (sumOut !== exp) begin
            n_err++;
            $display("FAIL extremes_zero_load: sumOut=%b expected %b", sumOut, exp);
        end
        $display("extremes_zero_load: sumOut=%b", sumOut);
        // Max input against most-negative weight (lane1) and max weight (lane0).
        drive(1'b0, 1'b0, 3'd7, {3'b100, 3'b011}, 12'd0);
        step();
        exp = {6'b100100, 6'b010101};   // -28, 21
        n_cmp++;
        if (sumOut !== exp) begin
            n_err++;
            $display("FAIL extremes_product: sumOut=%b expected %b", sumOut, exp);
        end
        $display("extremes_product: sumOut=%b", sumOut);
        step();
        exp = {6'b001000, 6'b101010};   // -56 wraps to 8, 42 wraps to -22
        n_cmp++;
        if (sumOut !== exp) begin
            n_err++;
            $display("FAIL extremes_wrap: sumOut=%b expected %b", sumOut, exp);
        end
        $display("extremes_wrap: sumOut=%b", sumOut);
    endtask

    task automatic test_back_to_back();
        logic [N*OUT_W-1:0] exp;
        // clr+bias load immediately followed by accumulation every cycle.
        drive(1'b1, 1'b1, 3'd0, 6'd0, {6'b111110, 6'd10});   // {-2, 10}
        step();
        drive(1'b0, 1'b0, 3'd3, {3'd2, 3'b110}, 12'd0);       // +6, -6
        step();
        drive(1'b0, 1'b0, 3'd4, {3'b111, 3'd1}, 12'd0);       // -4, +4
        step();
        exp = {6'd0, 6'd8};
        n_cmp++;
        if (sumOut !== exp) begin
            n_err++;
            $display("FAIL back_to_back: sumOut=%b expected %b", sumOut, exp);
        end
        $display("back_to_back: sumOut=%b", sumOut);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        drive(1'b0, 1'b0, 3'd0, 6'd0, 12'd0);
        #2;
        test_reset();
        test_accumulate();
        test_scaling();
        test_idle();
        test_clear_stored();
        test_wrap();
        test_bias_write_no_clr();
        test_extremes();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
